// File: rtl/fetch_queue_if.sv
// fetch_queue_if: memory, redirect and rf_read handshake bundle of the fetch queue (master = queue side)
interface fetch_queue_if #(
  parameter int DEPTH = 4
);
  logic [15:0] o_pc_addr;
  logic o_pc_rd;
  logic [15:0] i_pc_rddata;
  logic i_redirect;
  logic [15:0] i_redirect_pc;
  logic o_valid;
  logic [15:0] o_instr;
  logic [15:0] o_instr_pc;
  logic i_ready;
  logic [$clog2(DEPTH):0] o_count;
  modport master (
    output o_pc_addr, o_pc_rd, o_valid, o_instr, o_instr_pc, o_count,
    input i_pc_rddata, i_redirect, i_redirect_pc, i_ready
  );
  modport slave (
    input o_pc_addr, o_pc_rd, o_valid, o_instr, o_instr_pc, o_count,
    output i_pc_rddata, i_redirect, i_redirect_pc, i_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: credit-based instruction prefetch queue with PC-tagged entries and redirect flush; FETCHQ_BYPASS_EN adds an empty-queue response bypass
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input logic clk,
  input logic reset,
  fetch_queue_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int XW = CW + 1;
  typedef enum logic [1:0] {BOOT, RUN, FULL} state_t;
  state_t state_q, state_d;
  logic [15:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic inflight_q, inflight_d, drop_q, drop_d;
  logic [31:0] mem_q [DEPTH];
  logic [31:0] mem_d [DEPTH];
  logic credit, issue, push, byp, store, deq;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state_q <= BOOT;
    else state_q <= state_d;
  always_comb begin
    credit = XW'(count_q) + XW'(inflight_q) < XW'(DEPTH);
    state_d = (bus.i_redirect || credit || state_q == BOOT) ? RUN : FULL;
  end
  always_comb begin
    issue = state_q == RUN && credit && !bus.i_redirect;
    bus.o_pc_rd = issue;
    bus.o_pc_addr = fetch_pc_q;
  end
  always_comb begin
    push = inflight_q && !drop_q && !bus.i_redirect;
`ifdef FETCHQ_BYPASS_EN
    byp = push && count_q == '0;
`else
    byp = 1'b0;
`endif
    bus.o_valid = !bus.i_redirect && (count_q != '0 || byp);
    {bus.o_instr_pc, bus.o_instr} = byp ? {rsp_pc_q, bus.i_pc_rddata} : mem_q[rd_q];
    bus.o_count = count_q;
    store = push && !(byp && bus.i_ready);
    deq = bus.o_valid && bus.i_ready && count_q != '0;
    mem_d = mem_q;
    if (store) mem_d[wr_q] = {rsp_pc_q, bus.i_pc_rddata};
    wr_d = bus.i_redirect ? '0 : wr_q + PW'(store);
    rd_d = bus.i_redirect ? '0 : rd_q + PW'(deq);
    count_d = bus.i_redirect ? '0 : count_q + CW'(store) - CW'(deq);
    fetch_pc_d = bus.i_redirect ? bus.i_redirect_pc : issue ? fetch_pc_q + 16'd2 : fetch_pc_q;
    rsp_pc_d = issue ? fetch_pc_q : rsp_pc_q;
    inflight_d = issue;
    drop_d = bus.i_redirect && inflight_d;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
      inflight_q <= 1'b0;
      drop_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q <= rsp_pc_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
      inflight_q <= inflight_d;
      drop_q <= drop_d;
      mem_q <= mem_d;
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed vector table plus random-ready scoreboard run for fetch_queue
module tb_fetch_queue;
  localparam int DEPTH = 4;
  typedef struct {
    bit rst_n;
    bit rdy;
    bit rdr;
    logic [15:0] rpc;
    bit prd;
    logic [15:0] addr;
    bit v;
    logic [15:0] ipc;
    logic [2:0] cnt;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mem_rd_q = 1'b0;
  logic [15:0] mem_addr_q = '0;
  int checks = 0;
  int errors = 0;
  vec_t tbl[$];
  always #5 clk = ~clk;
  fetch_queue_if #(.DEPTH(DEPTH)) bus ();
  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (.clk(clk), .reset(reset), .bus(bus));
  always @(posedge clk) begin
    mem_rd_q <= bus.o_pc_rd;
    mem_addr_q <= bus.o_pc_addr;
  end
  assign bus.i_pc_rddata = mem_rd_q ? (mem_addr_q ^ 16'hA5A5) : 16'hDEAD;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic no_full_push();
    assert (!(reset && mem_rd_q && !bus.i_redirect && bus.o_count == 3'(DEPTH) && !(bus.o_valid && bus.i_ready)))
    else begin
      errors++;
      $display("FAIL push_when_full: count %0d with response arriving", bus.o_count);
    end
  endtask
  task automatic add(input int rst, input int rdy, input int rdr, input int rpc, input int prd, input int addr, input int v, input int ipc, input int cnt);
    vec_t t;
    t.rst_n = 1'(rst);
    t.rdy = 1'(rdy);
    t.rdr = 1'(rdr);
    t.rpc = 16'(rpc);
    t.prd = 1'(prd);
    t.addr = 16'(addr);
    t.v = 1'(v);
    t.ipc = 16'(ipc);
    t.cnt = 3'(cnt);
    tbl.push_back(t);
  endtask
  initial begin
    int exp_pc;
    int pops;
    bus.i_ready = 1'b0;
    bus.i_redirect = 1'b0;
    bus.i_redirect_pc = '0;
    add(0, 0, 0, 0, 0, 16'h0000, 0, 0, 0);
    add(1, 0, 0, 0, 0, 16'h0000, 0, 0, 0);
    add(1, 0, 0, 0, 1, 16'h0000, 0, 0, 0);
    add(1, 0, 0, 0, 1, 16'h0002, 0, 0, 0);
    add(1, 0, 0, 0, 1, 16'h0004, 1, 16'h0000, 1);
    add(1, 0, 0, 0, 1, 16'h0006, 1, 16'h0000, 2);
    add(1, 0, 0, 0, 0, 16'h0008, 1, 16'h0000, 3);
    for (int k = 0; k < 4; k++) add(1, 0, 0, 0, 0, 16'h0008, 1, 16'h0000, 4);
    add(1, 1, 0, 0, 0, 16'h0008, 1, 16'h0000, 4);
    add(1, 1, 0, 0, 0, 16'h0008, 1, 16'h0002, 3);
    add(1, 1, 0, 0, 1, 16'h0008, 1, 16'h0004, 2);
    add(1, 1, 0, 0, 1, 16'h000A, 1, 16'h0006, 1);
    add(1, 0, 0, 0, 1, 16'h000C, 1, 16'h0008, 1);
    add(1, 0, 0, 0, 1, 16'h000E, 1, 16'h0008, 2);
    add(1, 0, 1, 16'h0100, 0, 16'h0010, 0, 0, 3);
    add(1, 1, 0, 0, 1, 16'h0100, 0, 0, 0);
    add(1, 1, 0, 0, 1, 16'h0102, 0, 0, 0);
    add(1, 1, 0, 0, 1, 16'h0104, 1, 16'h0100, 1);
    add(1, 1, 1, 16'hFFFC, 0, 16'h0106, 0, 0, 1);
    add(1, 1, 0, 0, 1, 16'hFFFC, 0, 0, 0);
    add(1, 1, 0, 0, 1, 16'hFFFE, 0, 0, 0);
    add(1, 1, 0, 0, 1, 16'h0000, 1, 16'hFFFC, 1);
    add(1, 1, 0, 0, 1, 16'h0002, 1, 16'hFFFE, 1);
    add(1, 1, 0, 0, 1, 16'h0004, 1, 16'h0000, 1);
    add(1, 1, 0, 0, 1, 16'h0006, 1, 16'h0002, 1);
    add(1, 0, 0, 0, 1, 16'h0008, 1, 16'h0004, 1);
    add(1, 0, 0, 0, 1, 16'h000A, 1, 16'h0004, 2);
    add(0, 1, 0, 0, 0, 16'h0000, 0, 0, 0);
    add(1, 1, 0, 0, 0, 16'h0000, 0, 0, 0);
    add(1, 1, 0, 0, 1, 16'h0000, 0, 0, 0);
    add(1, 1, 0, 0, 1, 16'h0002, 0, 0, 0);
    add(1, 1, 0, 0, 1, 16'h0004, 1, 16'h0000, 1);
    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      reset = tbl[i].rst_n;
      bus.i_ready = tbl[i].rdy;
      bus.i_redirect = tbl[i].rdr;
      bus.i_redirect_pc = tbl[i].rpc;
      #1;
      no_full_push();
      chk($sformatf("row%0d pc_rd", i), 32'(bus.o_pc_rd), 32'(tbl[i].prd));
      chk($sformatf("row%0d pc_addr", i), 32'(bus.o_pc_addr), 32'(tbl[i].addr));
      chk($sformatf("row%0d valid", i), 32'(bus.o_valid), 32'(tbl[i].v));
      chk($sformatf("row%0d count", i), 32'(bus.o_count), 32'(tbl[i].cnt));
      if (!tbl[i].rst_n) begin
        chk($sformatf("row%0d reset instr_pc", i), 32'(bus.o_instr_pc), 32'h0);
        chk($sformatf("row%0d reset instr", i), 32'(bus.o_instr), 32'h0);
      end else if (tbl[i].v) begin
        chk($sformatf("row%0d instr_pc", i), 32'(bus.o_instr_pc), 32'(tbl[i].ipc));
        chk($sformatf("row%0d instr", i), 32'(bus.o_instr), 32'(tbl[i].ipc ^ 16'hA5A5));
      end
    end
    @(negedge clk);
    reset = 1'b0;
    bus.i_redirect = 1'b0;
    #1;
    chk("rand reset count", 32'(bus.o_count), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    exp_pc = 0;
    pops = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      bus.i_ready = 1'($urandom_range(0, 1));
      #1;
      no_full_push();
      if (bus.o_valid && bus.i_ready) begin
        chk("sb instr_pc", 32'(bus.o_instr_pc), 32'(16'(exp_pc)));
        chk("sb instr", 32'(bus.o_instr), 32'(16'(exp_pc) ^ 16'hA5A5));
        exp_pc += 2;
        pops++;
      end
      chk("sb count_bound", 32'(bus.o_count <= 3'(DEPTH)), 32'h1);
    end
    chk("sb progress", 32'(pops >= 100), 32'h1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
